// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FIFO read-side and downstream stream signals used by fifo_burst_reader.
// The master modport is the reader's view; slave is the FIFO/consumer environment's view.
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 3
);
   logic                  fifo_empty_i;
   logic [CNT_WIDTH-1:0]  fifo_count_i;
   logic [DATA_WIDTH-1:0] fifo_r_data_i;
   logic                  fifo_r_en_o;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] out_data_o;
   logic                  out_last_o;

   modport master (
      input  fifo_empty_i, fifo_count_i, fifo_r_data_i, out_ready_i,
      output fifo_r_en_o, out_valid_o, out_data_o, out_last_o
   );

   modport slave (
      output fifo_empty_i, fifo_count_i, fifo_r_data_i, out_ready_i,
      input  fifo_r_en_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller: drains a counted FIFO in full bursts or timeout-forced partial bursts.
// Optional burst statistics ports are enabled by defining FIFO_BURST_READER_PERF_EN.
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 3,
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_burst_reader_if.master bus
`ifdef FIFO_BURST_READER_PERF_EN
   ,
   output logic [15:0]         burst_cnt_o,
   output logic [15:0]         partial_cnt_o
`endif
);

   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_WIDTH-1:0] BURST_CNT  = CNT_WIDTH'(BURST_LEN);
   localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [TIMER_W-1:0]    timer_q, timer_d;
   logic [CNT_WIDTH-1:0]  beats_q, beats_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  valid_q, valid_d;
   logic                  pop;

   // A pop only happens when the output register is free or being drained this cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      beats_d = beats_q;
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      pop     = (state_q == BURST) && !bus.fifo_empty_i && (beats_q != '0)
                && (!valid_q || bus.out_ready_i);

      unique case (state_q)
         IDLE: begin
            if (bus.fifo_count_i >= BURST_CNT) begin
               state_d = BURST;
               beats_d = BURST_CNT;
            end else if (!bus.fifo_empty_i) begin
               state_d = WAIT;
               timer_d = '0;
            end
         end
         WAIT: begin
            if (bus.fifo_count_i >= BURST_CNT) begin
               state_d = BURST;
               beats_d = BURST_CNT;
            end else if (timer_q == TIMER_LAST) begin
               state_d = BURST;
               beats_d = bus.fifo_count_i;
            end else if (bus.fifo_empty_i) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         BURST: begin
            if (pop) begin
               beats_d = beats_q - CNT_WIDTH'(1);
               if (beats_q == CNT_WIDTH'(1)) begin
                  state_d = IDLE;
               end
            end else if (beats_q == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         data_d  = bus.fifo_r_data_i;
         last_d  = (beats_q == CNT_WIDTH'(1));
         valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
         valid_d = 1'b0;
      end
   end

`ifdef FIFO_BURST_READER_PERF_EN
   logic        burst_entry;
   logic        full_start;
   logic        partial_start;
   logic [15:0] burst_cnt_q, partial_cnt_q;

   // A burst entered with fewer than BURST_LEN entries can only be the timeout path.
   assign burst_entry   = (state_q != BURST) && (state_d == BURST);
   assign full_start    = burst_entry && (bus.fifo_count_i >= BURST_CNT);
   assign partial_start = burst_entry && (bus.fifo_count_i < BURST_CNT);
   assign burst_cnt_o   = burst_cnt_q;
   assign partial_cnt_o = partial_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         beats_q       <= '0;
         data_q        <= '0;
         last_q        <= 1'b0;
         valid_q       <= 1'b0;
`ifdef FIFO_BURST_READER_PERF_EN
         burst_cnt_q   <= '0;
         partial_cnt_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         beats_q       <= beats_d;
         data_q        <= data_d;
         last_q        <= last_d;
         valid_q       <= valid_d;
`ifdef FIFO_BURST_READER_PERF_EN
         burst_cnt_q   <= burst_cnt_q + 16'(full_start);
         partial_cnt_q <= partial_cnt_q + 16'(partial_start);
`endif
      end
   end

   assign bus.fifo_r_en_o = pop;
   assign bus.out_valid_o = valid_q;
   assign bus.out_data_o  = data_q;
   assign bus.out_last_o  = last_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO model feeds the reader and a
// monitor checks delivered beats against the write order and the burst framing rules.
module tb_fifo_burst_reader;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH  = 3;
   localparam int BURST_LEN  = 4;
   localparam int TIMEOUT    = 16;
   localparam int FIFO_DEPTH = 7;

   logic clk;
   logic rst_n;

   fifo_burst_reader_if #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) ifc ();

`ifdef FIFO_BURST_READER_PERF_EN
   logic [15:0] burst_cnt;
   logic [15:0] partial_cnt;
`endif

   fifo_burst_reader #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .BURST_LEN (BURST_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (ifc.master)
`ifdef FIFO_BURST_READER_PERF_EN
      ,
      .burst_cnt_o  (burst_cnt),
      .partial_cnt_o(partial_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run  = 0;
   int fail_count = 0;
   int pops       = 0;
   int delivered  = 0;
   int cyc        = 0;

   logic [DATA_WIDTH-1:0] fifo_q[$];
   logic [DATA_WIDTH-1:0] wr_req_q[$];
   logic [DATA_WIDTH-1:0] exp_q[$];
   logic [DATA_WIDTH-1:0] log_data[$];
   logic                  log_last[$];
   int                    log_cyc[$];

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         wr_req_q.push_back($urandom);
      end
   endtask

   task automatic waitBeats(input int n, input int budget);
      int k;
      k = 0;
      while (log_data.size() < n && k < budget) begin
         @(posedge clk); #2;
         k++;
      end
   endtask

   task automatic settle();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || wr_req_q.size() != 0) && k < 200) begin
         @(posedge clk); #2;
         k++;
      end
      checkOutput("settle_drained", 64'(exp_q.size()), 64'(0));
      repeat (3) begin
         @(posedge clk); #2;
      end
      log_data.delete();
      log_last.delete();
      log_cyc.delete();
   endtask

   task automatic checkLasts(input string tag, input int n, input logic [7:0] pattern);
      checkOutput({tag, "_beat_count"}, 64'(log_last.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < log_last.size()) begin
            checkOutput($sformatf("%s_last%0d", tag, i), 64'(log_last[i]), 64'(pattern[i]));
         end
      end
   endtask

   // FIFO model: pops on the sampled strobe, accepts one queued write per cycle.
   initial begin : fifo_model
      logic                  pop_seen;
      logic [DATA_WIDTH-1:0] d;
      ifc.fifo_empty_i  = 1'b1;
      ifc.fifo_count_i  = '0;
      ifc.fifo_r_data_i = '0;
      forever begin
         @(negedge clk);
         pop_seen = ifc.fifo_r_en_o;
         if (pop_seen) begin
            checkOutput("pop_not_empty", 64'(ifc.fifo_empty_i), 64'(0));
         end
         @(posedge clk); #1;
         if (pop_seen && rst_n && fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            pops++;
         end
         if (wr_req_q.size() > 0 && fifo_q.size() < FIFO_DEPTH) begin
            d = wr_req_q.pop_front();
            fifo_q.push_back(d);
            exp_q.push_back(d);
         end
         ifc.fifo_empty_i  = (fifo_q.size() == 0);
         ifc.fifo_count_i  = CNT_WIDTH'(fifo_q.size());
         ifc.fifo_r_data_i = (fifo_q.size() > 0) ? fifo_q[0] : '0;
         cyc++;
      end
   end

   // Monitor: beats are accepted on the next rising edge when valid and ready are both high.
   initial begin : monitor
      int                    beats_in_burst;
      logic                  stall_held;
      logic [DATA_WIDTH-1:0] held_data;
      logic                  held_last;
      logic [DATA_WIDTH-1:0] exp_d;
      beats_in_burst = 0;
      stall_held     = 1'b0;
      held_data      = '0;
      held_last      = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            while (delivered < pops && exp_q.size() > 0) begin
               exp_d = exp_q.pop_front();
               delivered++;
            end
            delivered      = pops;
            beats_in_burst = 0;
            stall_held     = 1'b0;
         end else begin
            if (stall_held) begin
               checkOutput("stall_valid", 64'(ifc.out_valid_o), 64'(1));
               checkOutput("stall_data", 64'(ifc.out_data_o), 64'(held_data));
               checkOutput("stall_last", 64'(ifc.out_last_o), 64'(held_last));
            end
            if (ifc.out_valid_o && ifc.out_ready_i) begin
               if (exp_q.size() == 0) begin
                  checkOutput("beat_unexpected", 64'(exp_q.size()), 64'(1));
               end else begin
                  exp_d = exp_q.pop_front();
                  checkOutput("beat_data", 64'(ifc.out_data_o), 64'(exp_d));
               end
               delivered++;
               beats_in_burst++;
               checkOutput("burst_len_bound", 64'(beats_in_burst <= BURST_LEN), 64'(1));
               if (ifc.out_last_o) begin
                  beats_in_burst = 0;
               end
               log_data.push_back(ifc.out_data_o);
               log_last.push_back(ifc.out_last_o);
               log_cyc.push_back(cyc);
            end
            stall_held = ifc.out_valid_o && !ifc.out_ready_i;
            held_data  = ifc.out_data_o;
            held_last  = ifc.out_last_o;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int start;
      int p0;
      int k;
`ifdef FIFO_BURST_READER_PERF_EN
      logic [15:0] b0;
      logic [15:0] pc0;
`endif
      rst_n           = 1'b0;
      ifc.out_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_valid", 64'(ifc.out_valid_o), 64'(0));
      checkOutput("rst_last", 64'(ifc.out_last_o), 64'(0));
      checkOutput("rst_data", 64'(ifc.out_data_o), 64'(0));
      checkOutput("rst_ren", 64'(ifc.fifo_r_en_o), 64'(0));
`ifdef FIFO_BURST_READER_PERF_EN
      checkOutput("rst_burst_cnt", 64'(burst_cnt), 64'(0));
      checkOutput("rst_partial_cnt", 64'(partial_cnt), 64'(0));
`endif
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // T1: full burst of four back-to-back, then the leftover entry as a timeout burst.
      ifc.out_ready_i = 1'b1;
      applyStimulus(5);
      waitBeats(5, 150);
      checkLasts("t1", 5, 8'b1_1000);
      if (log_cyc.size() >= 5) begin
         checkOutput("t1_back_to_back", 64'(log_cyc[3] - log_cyc[0]), 64'(3));
         checkOutput("t1_timeout_gap", 64'(log_cyc[4] - log_cyc[3] >= TIMEOUT), 64'(1));
      end
      settle();

      // T2: two entries only, released by the timeout.
`ifdef FIFO_BURST_READER_PERF_EN
      pc0 = partial_cnt;
`endif
      start = cyc;
      applyStimulus(2);
      waitBeats(2, 150);
      checkLasts("t2", 2, 8'b10);
      if (log_cyc.size() >= 2) begin
         checkOutput("t2_waited", 64'(log_cyc[0] - start >= TIMEOUT), 64'(1));
         checkOutput("t2_consecutive", 64'(log_cyc[1] - log_cyc[0]), 64'(1));
      end
`ifdef FIFO_BURST_READER_PERF_EN
      checkOutput("t2_partial_cnt", 64'(partial_cnt - pc0), 64'(1));
`endif
      settle();

      // T3: stall right after the first beat appears.
      p0 = pops;
      applyStimulus(4);
      k = 0;
      while (!ifc.out_valid_o && k < 100) begin
         @(posedge clk); #2;
         k++;
      end
      checkOutput("t3_valid_seen", 64'(ifc.out_valid_o), 64'(1));
      ifc.out_ready_i = 1'b0;
      repeat (3) begin
         @(posedge clk); #2;
      end
      checkOutput("t3_single_pop", 64'(pops - p0), 64'(1));
      checkOutput("t3_still_valid", 64'(ifc.out_valid_o), 64'(1));
      ifc.out_ready_i = 1'b1;
      waitBeats(4, 100);
      checkLasts("t3", 4, 8'b1000);
      settle();

      // T4: fourth entry arrives before the timeout and promotes WAIT to a full burst.
`ifdef FIFO_BURST_READER_PERF_EN
      b0  = burst_cnt;
      pc0 = partial_cnt;
`endif
      start = cyc;
      applyStimulus(3);
      while (cyc < start + 10) begin
         @(posedge clk); #2;
      end
      applyStimulus(1);
      waitBeats(4, 100);
      checkLasts("t4", 4, 8'b1000);
      if (log_cyc.size() >= 4) begin
         checkOutput("t4_before_timeout", 64'(log_cyc[0] - start <= TIMEOUT - 1), 64'(1));
         checkOutput("t4_back_to_back", 64'(log_cyc[3] - log_cyc[0]), 64'(3));
      end
`ifdef FIFO_BURST_READER_PERF_EN
      checkOutput("t4_burst_cnt", 64'(burst_cnt - b0), 64'(1));
      checkOutput("t4_partial_cnt", 64'(partial_cnt - pc0), 64'(0));
`endif
      settle();

      // T5: reset after two pops; the popped-but-undelivered beat is lost, the rest survive.
      p0 = pops;
      applyStimulus(4);
      k = 0;
      while (pops < p0 + 2 && k < 100) begin
         @(posedge clk); #2;
         k++;
      end
      checkOutput("t5_two_pops", 64'(pops - p0), 64'(2));
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_valid_low", 64'(ifc.out_valid_o), 64'(0));
      checkOutput("t5_ren_low", 64'(ifc.fifo_r_en_o), 64'(0));
      repeat (2) begin
         @(posedge clk); #2;
      end
      checkOutput("t5_fifo_kept", 64'(fifo_q.size()), 64'(2));
`ifdef FIFO_BURST_READER_PERF_EN
      checkOutput("t5_burst_cnt_rst", 64'(burst_cnt), 64'(0));
      checkOutput("t5_partial_cnt_rst", 64'(partial_cnt), 64'(0));
`endif
      #1;
      rst_n = 1'b1;
      settle();

      // T6: random writes and backpressure.
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #2;
         ifc.out_ready_i = ($urandom_range(0, 3) != 0);
         if (wr_req_q.size() == 0 && $urandom_range(0, 2) == 0) begin
            applyStimulus(1);
         end
      end
      ifc.out_ready_i = 1'b1;
      settle();
      checkOutput("t6_all_delivered", 64'(delivered), 64'(pops));

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
